decode_queue: RTL and testbench

//  Buffered, parametrised RV64I/RV32I instruction decoder between fetch and execute.

---
 rtl/decode_queue.sv | 194 +++++++++++++++++++
 tb/tb_decode_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV64I/RV32I decoder feeding a DEPTH-entry FIFO; decode is combinational, the FIFO adds one cycle.
// in_ready reflects FIFO space only; the head entry holds while out_valid && !out_ready.
module decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_class
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011, OP_IMM  = 7'b0010011, OP_IMM32 = 7'b0011011,
                         OP_STORE  = 7'b0100011, OP_OP   = 7'b0110011, OP_OP32  = 7'b0111011,
                         OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL   = 7'b1101111,
                         OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111, OP_SYSTEM = 7'b1110011,
                         OP_FENCE  = 7'b0001111;

  localparam int C_LOAD = 0, C_STORE = 1, C_ALUREG = 2, C_SYSTEM = 3, C_JAL = 4, C_JALR = 5,
                 C_LUI = 6, C_AUIPC = 7, C_BRANCH = 8, C_WORD = 9, C_FENCE = 10, C_ILLEGAL = 11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [11:0]     cls;
  } entry_t;

  entry_t      dec;
  entry_t      head;
  entry_t      out_e;
  logic        illegal;
  logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  // Immediates are formed at 64 bits and truncated, so XLEN=32 needs no special replication.
  assign imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};

  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    case (in_instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.funct3 = in_instr[14:12];
        dec.imm    = imm_i[XLEN-1:0];
        dec.cls[C_LOAD]   = (in_instr[6:0] == OP_LOAD);
        dec.cls[C_JALR]   = (in_instr[6:0] == OP_JALR);
        dec.cls[C_SYSTEM] = (in_instr[6:0] == OP_SYSTEM);
        dec.cls[C_FENCE]  = (in_instr[6:0] == OP_FENCE);
      end
      OP_IMM, OP_IMM32: begin
        illegal    = (XLEN == 32) && (in_instr[6:0] == OP_IMM32);
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.funct3 = in_instr[14:12];
        dec.cls[C_WORD] = (in_instr[6:0] == OP_IMM32);
        if (in_instr[13:12] == 2'b01) begin
          // Only RV64 OP-IMM shifts take a 6-bit shamt; instr[25] then belongs to shamt, not funct7.
          if ((XLEN == 64) && (in_instr[6:0] == OP_IMM)) begin
            dec.imm[5:0] = in_instr[25:20];
            dec.funct7   = {in_instr[31:26], 1'b0};
          end else begin
            dec.imm[4:0] = in_instr[24:20];
            dec.funct7   = in_instr[31:25];
          end
        end else begin
          dec.imm = imm_i[XLEN-1:0];
        end
      end
      OP_OP, OP_OP32: begin
        illegal    = (XLEN == 32) && (in_instr[6:0] == OP_OP32);
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = in_instr[14:12];
        dec.funct7 = in_instr[31:25];
        dec.cls[C_WORD]   = (in_instr[6:0] == OP_OP32);
        dec.cls[C_ALUREG] = (in_instr[6:0] == OP_OP);
      end
      OP_STORE, OP_BRANCH: begin
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = in_instr[14:12];
        dec.imm    = (in_instr[6:0] == OP_STORE) ? imm_s[XLEN-1:0] : imm_b[XLEN-1:0];
        dec.cls[C_STORE]  = (in_instr[6:0] == OP_STORE);
        dec.cls[C_BRANCH] = (in_instr[6:0] == OP_BRANCH);
      end
      OP_JAL: begin
        dec.rd  = in_instr[11:7];
        dec.imm = imm_j[XLEN-1:0];
        dec.cls[C_JAL] = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = in_instr[11:7];
        dec.imm = imm_u[XLEN-1:0];
        dec.cls[C_LUI]   = (in_instr[6:0] == OP_LUI);
        dec.cls[C_AUIPC] = (in_instr[6:0] == OP_AUIPC);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec              = '0;
      dec.pc           = in_pc;
      dec.cls[C_ILLEGAL] = 1'b1;
    end
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  entry_t        mem_q [DEPTH];
  logic          push, pop;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= dec;
  end

  // Outputs read zero whenever the queue is empty, so storage needs no reset.
  assign head  = mem_q[rd_ptr_q];
  assign out_e = out_valid ? head : '0;

  assign out_pc     = out_e.pc;
  assign out_rs1    = out_e.rs1;
  assign out_rs2    = out_e.rs2;
  assign out_rd     = out_e.rd;
  assign out_opcode = out_e.opcode;
  assign out_funct3 = out_e.funct3;
  assign out_funct7 = out_e.funct7;
  assign out_imm    = out_e.imm;
  assign out_class  = out_e.cls;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: an RV64/DEPTH=2 and an RV32/DEPTH=4 instance share stimulus,
// each checked against its own queue-of-decoded-entries reference model.
module tb_decode_queue;
  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid;
  logic [63:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3;
  logic [11:0] a_cls;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3;
  logic [11:0] b_cls;

  decode_queue #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_opcode(a_op),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_class(a_cls));

  decode_queue #(.XLEN(32), .DEPTH(4)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_opcode(b_op),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_class(b_cls));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [11:0] cls;
  } exp_t;

  localparam int LD = 0, ST = 1, ALUREG = 2, SYS = 3, JAL = 4, JALR = 5,
                 LUI = 6, AUIPC = 7, BR = 8, WD = 9, FN = 10, ILL = 11;

  int   checks = 0;
  int   errors = 0;
  exp_t q64[$];
  exp_t q32[$];
  logic [6:0] ops [14] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b0100011, 7'b0110011,
                           7'b0111011, 7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111,
                           7'b0010111, 7'b1110011, 7'b0001111, 7'b1010011};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two's-complement sign extension of a bits-wide value, by arithmetic.
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = 64'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    exp_t e;
    byte  fmt;
    logic [6:0] op;
    logic wide;
    op = ins[6:0];
    e = '0;
    e.pc = pc;
    fmt = "X";
    case (op)
      7'b0000011: begin fmt = "I"; e.cls[LD] = 1'b1; end
      7'b0010011: fmt = "I";
      7'b0011011: if (xlen == 64) begin fmt = "I"; e.cls[WD] = 1'b1; end
      7'b0100011: begin fmt = "S"; e.cls[ST] = 1'b1; end
      7'b0110011: begin fmt = "R"; e.cls[ALUREG] = 1'b1; end
      7'b0111011: if (xlen == 64) begin fmt = "R"; e.cls[WD] = 1'b1; end
      7'b1100011: begin fmt = "B"; e.cls[BR] = 1'b1; end
      7'b1100111: begin fmt = "I"; e.cls[JALR] = 1'b1; end
      7'b1101111: begin fmt = "J"; e.cls[JAL] = 1'b1; end
      7'b0110111: begin fmt = "U"; e.cls[LUI] = 1'b1; end
      7'b0010111: begin fmt = "U"; e.cls[AUIPC] = 1'b1; end
      7'b1110011: begin fmt = "I"; e.cls[SYS] = 1'b1; end
      7'b0001111: begin fmt = "I"; e.cls[FN] = 1'b1; end
      default:    fmt = "X";
    endcase
    if (fmt == "X") begin
      e.cls = 12'h800;
    end else begin
      e.opcode = op;
      if (fmt inside {"I", "R", "U", "J"}) e.rd = ins[11:7];
      if (fmt inside {"I", "R", "S", "B"}) begin e.rs1 = ins[19:15]; e.funct3 = ins[14:12]; end
      if (fmt inside {"R", "S", "B"}) e.rs2 = ins[24:20];
      if (fmt == "R") e.funct7 = ins[31:25];
      case (fmt)
        "I": e.imm = sx(64'(ins[31:20]), 12);
        "S": e.imm = sx(64'({ins[31:25], ins[11:7]}), 12);
        "B": e.imm = sx(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        "J": e.imm = sx(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
        "U": e.imm = sx(64'({ins[31:12], 12'b0}), 32);
        default: e.imm = '0;
      endcase
      if ((op == 7'b0010011 || op == 7'b0011011) && ins[13:12] == 2'b01) begin
        wide = (xlen == 64) && (op == 7'b0010011);
        e.imm    = wide ? 64'(ins[25:20]) : 64'(ins[24:20]);
        e.funct7 = wide ? {ins[31:26], 1'b0} : ins[31:25];
      end
    end
    if (xlen == 32) begin
      e.pc[63:32]  = '0;
      e.imm[63:32] = '0;
    end
    return e;
  endfunction

  function automatic exp_t obs_a();
    return {a_pc, a_rs1, a_rs2, a_rd, a_op, a_f3, a_f7, a_imm, a_cls};
  endfunction

  function automatic exp_t obs_b();
    return {32'b0, b_pc, b_rs1, b_rs2, b_rd, b_op, b_f3, b_f7, 32'b0, b_imm, b_cls};
  endfunction

  // One clock: drive inputs, check readiness, advance the models, check the head after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    logic push_a, pop_a, push_b, pop_b;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready64", a_in_ready, q64.size() < 2);
    chk("in_ready32", b_in_ready, q32.size() < 4);
    push_a = v && (q64.size() < 2);
    push_b = v && (q32.size() < 4);
    pop_a  = ordy && (q64.size() > 0);
    pop_b  = ordy && (q32.size() > 0);
    @(posedge clk);
    if (fl) begin
      q64.delete();
      q32.delete();
    end else begin
      if (pop_a) void'(q64.pop_front());
      if (pop_b) void'(q32.pop_front());
      if (push_a) q64.push_back(ref_decode(ins, pc, 64));
      if (push_b) q32.push_back(ref_decode(ins, pc, 32));
    end
    #1;
    chk("out_valid64", a_out_valid, q64.size() > 0);
    chk("out_valid32", b_out_valid, q32.size() > 0);
    if (q64.size() > 0) chk("head64", obs_a(), q64[0]);
    if (q32.size() > 0) chk("head32", obs_b(), q32[0]);
  endtask

  initial begin
    logic [31:0] r, ins;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid64", a_out_valid, 1'b0);
    chk("rst_ready64", a_in_ready, 1'b1);
    chk("rst_data64", obs_a(), '0);
    chk("rst_valid32", b_out_valid, 1'b0);
    chk("rst_data32", obs_b(), '0);
    rst_n = 1'b1;

    // addi x5,x4,16
    step(1'b1, 32'h01020293, 64'h1000, 1'b1, 1'b0);
    chk("addi_valid", a_out_valid, 1'b1);
    chk("addi_rd", a_rd, 5'd5);
    chk("addi_rs1", a_rs1, 5'd4);
    chk("addi_imm", a_imm, 64'h10);
    chk("addi_class", a_cls, 12'h000);
    // beq x8,x9
    step(1'b1, 32'hFE940F63, 64'h1004, 1'b1, 1'b0);
    chk("beq_class", a_cls, 12'h100);
    chk("beq_rs1", a_rs1, 5'd8);
    chk("beq_rs2", a_rs2, 5'd9);
    chk("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_F7FE);
    // lui x10
    step(1'b1, 32'h80000537, 64'h1008, 1'b1, 1'b0);
    chk("lui_class", a_cls, 12'h040);
    chk("lui_imm", a_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", b_imm, 32'h8000_0000);
    // addiw x1,x0,1
    step(1'b1, 32'h0010009B, 64'h100C, 1'b1, 1'b0);
    chk("addiw_class64", a_cls, 12'h200);
    chk("addiw_imm64", a_imm, 64'h1);
    chk("addiw_class32", b_cls, 12'h800);
    step(1'b1, 32'h00000000, 64'h1010, 1'b1, 1'b0);
    chk("zero_class64", a_cls, 12'h800);
    chk("zero_class32", b_cls, 12'h800);
    chk("zero_pc64", a_pc, 64'h1010);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Fill DEPTH=2 with execute stalled; the third instruction is held by fetch.
    step(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0);
    chk("full_ready", a_in_ready, 1'b0);
    step(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0);
    chk("held_head", a_pc, 64'h2000);
    step(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
    chk("drain_1", a_pc, 64'h2004);
    step(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
    chk("drain_2", a_pc, 64'h2008);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Flush with a concurrent push: everything, including the push, is dropped.
    step(1'b1, 32'h00500293, 64'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 64'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 64'h3008, 1'b0, 1'b1);
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ready", a_in_ready, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    chk("flush_lost", a_out_valid, 1'b0);

    // Asynchronous reset with two entries queued.
    step(1'b1, 32'h00800413, 64'h4000, 1'b0, 1'b0);
    step(1'b1, 32'h00900493, 64'h4004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid64", a_out_valid, 1'b0);
    chk("arst_ready64", a_in_ready, 1'b1);
    chk("arst_valid32", b_out_valid, 1'b0);
    q64.delete();
    q32.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 7) == 0) ins = r;
      else ins = {r[31:7], ops[$urandom_range(0, 13)]};
      step($urandom_range(0, 3) != 0, ins, {$urandom, $urandom} & ~64'h3,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
